vec_register_file: RTL and testbench

- Parametrised scalar/vector register file for the SIMD datapath, feeding decode-stage operand reads and taking writeback.
- Two banks share one address space: MSB of the address selects the vector bank (1) or the scalar bank (0).
- Adds per-lane write masking, same-cycle write-to-read bypass, an out-of-range address guard and a sequential post-reset clear sequence with a busy flag.

---
 rtl/vec_register_file.sv | 125 ++++++++++++
 tb/tb_vec_register_file.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_register_file.sv
// rtl/vec_register_file.sv - scalar/vector register file with lane masks, bypass and post-reset clear
module vec_register_file #(
  parameter int LANE_W = 32,
  parameter int LANES  = 4,
  parameter int ADDR_W = 6,
  parameter int NREGS  = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [LANES-1:0]          wmask,
  input  logic [ADDR_W-1:0]         a1,
  input  logic [ADDR_W-1:0]         a2,
  input  logic [ADDR_W-1:0]         a3,
  input  logic [LANES*LANE_W-1:0]   wd,
  output logic [LANES*LANE_W-1:0]   rd1,
  output logic [LANES*LANE_W-1:0]   rd2,
  output logic                      busy
);

  localparam int VW    = LANES * LANE_W;
  localparam int IDX_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  // busy is the inverse of this flop so that a zero power-up state reads as busy
  logic              ready_q, ready_d;

  logic [LANE_W-1:0] scalar_q [NREGS];
  logic [VW-1:0]     vec_q    [NREGS];

  logic [IDX_W-1:0]  w_idx;
  logic              w_vec;
  logic              wr_legal;
  logic [VW-1:0]     vec_merged;

  assign busy  = ~ready_q;
  assign w_idx = a3[IDX_W-1:0];
  assign w_vec = a3[ADDR_W-1];

  // A write takes effect only in READY, outside reset, to a real register
  assign wr_legal = we && !rst && (state_q == ST_READY) && (w_idx != '0)
                    && ({1'b0, w_idx} < (IDX_W+1)'(NREGS));

  // Post-write image of the addressed vector: masked-in lanes from wd, others kept
  always_comb begin
    vec_merged = vec_q[w_idx];
    for (int i = 0; i < LANES; i++) begin
      if (wmask[i]) vec_merged[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
    end
  end

  // Control state register; reset always wins and restarts the clear sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic: sweep every index once, then settle in READY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_READY: ready_d = 1'b1;
      default:  ready_d = 1'b0;
    endcase
  end

  // Storage: clear sweep has priority, otherwise apply legal writeback
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      scalar_q[cnt_q] <= '0;
      vec_q[cnt_q]    <= '0;
    end else if (wr_legal) begin
      if (w_vec) vec_q[w_idx]    <= vec_merged;
      else       scalar_q[w_idx] <= wd[LANE_W-1:0];
    end
  end

  // Two independent combinational read ports with same-cycle write bypass
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [IDX_W-1:0]  ridx;
    logic [VW-1:0]     rdata;
    rd1 = '0;
    rd2 = '0;
    for (int p = 0; p < 2; p++) begin
      ra    = (p == 0) ? a1 : a2;
      ridx  = ra[IDX_W-1:0];
      rdata = '0;
      if ((state_q == ST_READY) && (ridx != '0) && ({1'b0, ridx} < (IDX_W+1)'(NREGS))) begin
        if (wr_legal && (ra == a3)) begin
          if (w_vec) rdata = vec_merged;
          else       rdata = {{(VW-LANE_W){1'b0}}, wd[LANE_W-1:0]};
        end else if (ra[ADDR_W-1]) begin
          rdata = vec_q[ridx];
        end else begin
          rdata = {{(VW-LANE_W){1'b0}}, scalar_q[ridx]};
        end
      end
      if (p == 0) rd1 = rdata;
      else        rd2 = rdata;
    end
  end

endmodule

// File: tb/tb_vec_register_file.sv
// tb/tb_vec_register_file.sv - randomized scoreboard bench for vec_register_file
module tb_vec_register_file;

  localparam int NREGS = 25;

  logic         clk = 1'b0;
  logic         rst, we;
  logic [3:0]   wmask;
  logic [5:0]   a1, a2, a3;
  logic [127:0] wd;
  logic [127:0] rd1, rd2;
  logic         busy;

  vec_register_file #(.LANE_W(32), .LANES(4), .ADDR_W(6), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .we(we), .wmask(wmask), .a1(a1), .a2(a2), .a3(a3),
    .wd(wd), .rd1(rd1), .rd2(rd2), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] r1;
    logic [127:0] r2;
    logic         b;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;

  // Reference model: plain arrays, a ready flag and a count of remaining clear cycles
  logic [31:0]  sm [NREGS];
  logic [127:0] vm [NREGS];
  bit           mready = 0;
  int           clear_left = 0;

  logic [127:0] rd1_s, rd2_s;
  logic         busy_s;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] a);
    return (a[4:0] != 0) && (int'(a[4:0]) < NREGS);
  endfunction

  function automatic logic [127:0] apply_mask(input logic [127:0] old, input logic [127:0] d,
                                              input logic [3:0] m);
    logic [127:0] v = old;
    for (int i = 0; i < 4; i++) if (m[i]) v[i*32 +: 32] = d[i*32 +: 32];
    return v;
  endfunction

  function automatic logic [127:0] exp_read(input logic [5:0] a);
    bit byp;
    if (!mready || !legal(a)) return '0;
    byp = we && !rst && legal(a3) && (a == a3);
    if (a[5]) return byp ? apply_mask(vm[a[4:0]], wd, wmask) : vm[a[4:0]];
    return byp ? {96'b0, wd[31:0]} : {96'b0, sm[a[4:0]]};
  endfunction

  task automatic model_edge();
    if (rst) begin
      mready = 0;
      clear_left = NREGS;
      for (int i = 0; i < NREGS; i++) begin sm[i] = '0; vm[i] = '0; end
    end else if (!mready && clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) mready = 1;
    end else if (mready && we && legal(a3)) begin
      if (a3[5]) vm[a3[4:0]] = apply_mask(vm[a3[4:0]], wd, wmask);
      else       sm[a3[4:0]] = wd[31:0];
    end
  endtask

  // One cycle: drive, queue expectation, sample mid-cycle, advance the model at the edge
  task automatic step(input logic r, input logic w, input logic [3:0] m, input logic [5:0] x1,
                      input logic [5:0] x2, input logic [5:0] x3, input logic [127:0] d);
    exp_t e;
    rst = r; we = w; wmask = m; a1 = x1; a2 = x2; a3 = x3; wd = d;
    e.r1 = exp_read(x1);
    e.r2 = exp_read(x2);
    e.b  = !mready;
    expq.push_back(e);
    @(negedge clk);
    rd1_s = rd1; rd2_s = rd2; busy_s = busy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic [5:0] x1, input logic [5:0] x2);
    step(1'b0, 1'b0, 4'h0, x1, x2, 6'h00, '0);
  endtask

  // Steps with rst low until busy drops, returning how many sampled cycles were busy
  task automatic count_busy(output int n);
    n = 0;
    do begin
      idle(6'h05, 6'h25);
      if (busy_s) n++;
    end while (busy_s && n < 200);
  endtask

  // Monitor: compares every sampled cycle against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("rd1", rd1, e.r1);
      chk("rd2", rd2, e.r2);
      chk("busy", {127'b0, busy}, {127'b0, e.b});
    end
  end

  initial begin
    int n;
    logic [127:0] ones;
    ones = '1;
    rst = 0; we = 0; wmask = 0; a1 = 0; a2 = 0; a3 = 0; wd = '0;
    @(posedge clk); #1;

    // Initial reset and clear length
    step(1'b1, 1'b0, 4'h0, 6'h05, 6'h00, 6'h00, '0);
    chk("busy_in_reset", {127'b0, busy_s}, 128'd1);
    count_busy(n);
    chk("clear_len_first", 128'(n), 128'd25);

    // Preload then reset: clear erases it
    step(1'b0, 1'b1, 4'h0, 6'h05, 6'h00, 6'h05, 128'hDEADBEEF);
    idle(6'h05, 6'h00);
    chk("preload", rd1_s, 128'hDEADBEEF);
    step(1'b1, 1'b0, 4'h0, 6'h05, 6'h00, 6'h00, '0);
    count_busy(n);
    chk("clear_len_second", 128'(n), 128'd25);
    idle(6'h05, 6'h00);
    chk("cleared_scalar5", rd1_s, 128'd0);

    // Reset re-asserted mid-clear restarts the count
    step(1'b1, 1'b0, 4'h0, 6'h00, 6'h00, 6'h00, '0);
    repeat (10) idle(6'h05, 6'h25);
    step(1'b1, 1'b0, 4'h0, 6'h00, 6'h00, 6'h00, '0);
    count_busy(n);
    chk("clear_len_restart", 128'(n), 128'd25);

    // Scalar write zero-extends; vector bank at same index untouched
    step(1'b0, 1'b1, 4'hF, 6'h00, 6'h00, 6'h03, 128'h1111_2222_3333_4444_1111_2222_3333_4444);
    idle(6'h03, 6'h23);
    chk("scalar_zext", rd1_s, 128'h3333_4444);
    chk("vec_bank_untouched", rd2_s, 128'd0);

    // Lane mask with same-cycle bypass; scalar index 2 is a different register
    step(1'b0, 1'b1, 4'hF, 6'h00, 6'h00, 6'h22, {4{32'hAAAAAAAA}});
    step(1'b0, 1'b1, 4'b0101, 6'h22, 6'h02, 6'h22, {4{32'h55555555}});
    chk("bypass_merge", rd1_s, 128'hAAAAAAAA_55555555_AAAAAAAA_55555555);
    chk("no_cross_bank_bypass", rd2_s, 128'd0);
    idle(6'h22, 6'h22);
    chk("masked_stored", rd1_s, 128'hAAAAAAAA_55555555_AAAAAAAA_55555555);
    step(1'b0, 1'b1, 4'h0, 6'h22, 6'h00, 6'h22, ones);
    chk("zero_mask_noop", rd1_s, 128'hAAAAAAAA_55555555_AAAAAAAA_55555555);

    // Guards: index 0 and out-of-range writes dropped, last legal index kept
    step(1'b0, 1'b1, 4'hF, 6'h00, 6'h00, 6'h18, 128'h1234_5678);
    step(1'b0, 1'b1, 4'hF, 6'h00, 6'h00, 6'h00, ones);
    step(1'b0, 1'b1, 4'hF, 6'h20, 6'h20, 6'h20, ones);
    chk("idx0_no_bypass", rd1_s, 128'd0);
    step(1'b0, 1'b1, 4'hF, 6'h19, 6'h00, 6'h19, ones);
    chk("oor_no_bypass", rd1_s, 128'd0);
    step(1'b0, 1'b1, 4'hF, 6'h3F, 6'h00, 6'h3F, ones);
    idle(6'h19, 6'h3F);
    chk("oor_scalar_read", rd1_s, 128'd0);
    chk("oor_vec_read", rd2_s, 128'd0);
    idle(6'h18, 6'h00);
    chk("idx24_kept", rd1_s, 128'h1234_5678);

    // Writes during clear are dropped
    step(1'b1, 1'b0, 4'h0, 6'h00, 6'h00, 6'h00, '0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 4'hF, 6'h04, 6'h24, 6'h04, ones);
    idle(6'h04, 6'h24);
    chk("no_write_in_clear", rd1_s, 128'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [5:0] x3;
      logic [5:0] x1;
      logic [5:0] x2;
      x3 = 6'($urandom);
      x1 = ($urandom_range(0, 2) == 0) ? x3 : 6'($urandom);
      x2 = ($urandom_range(0, 2) == 0) ? x3 : (($urandom_range(0, 3) == 0) ? x1 : 6'($urandom));
      step(($urandom_range(0, 199) == 0), 1'($urandom), 4'($urandom), x1, x2, x3,
           {$urandom, $urandom, $urandom, $urandom});
    end

    repeat (2) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
